// File: rtl/sync_fifo_flags_pkg.sv
// sync_fifo_pkg: read-mode constants and sizing helper shared by the sync_fifo_flags slice
package sync_fifo_pkg;
    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/fifo_wrap_ctr.sv
// fifo_wrap_ctr: modulo-N pointer with increment enable and async active-low clear
module fifo_wrap_ctr #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] value
);
    logic [W-1:0] value_q, value_d;
    always_comb value_d = !inc ? value_q : (value_q == W'(N - 1)) ? '0 : value_q + W'(1);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) value_q <= '0;
        else value_q <= value_d;
    end
    assign value = value_q;
endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy count, threshold flags, optional FWFT and error pulses
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int DATA_DEPTH    = 8,
    parameter int AFULL_THRESH  = DATA_DEPTH - 1,
    parameter int AEMPTY_THRESH = 1,
    parameter int FWFT          = FIFO_STD
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [DATA_WIDTH-1:0]            din,
    input  logic                             write_en,
    input  logic                             read_en,
    output logic [DATA_WIDTH-1:0]            dout,
    output logic                             dout_valid,
    output logic                             empty,
    output logic                             full,
    output logic                             almost_full,
    output logic                             almost_empty,
    output logic [cnt_width(DATA_DEPTH)-1:0] count,
    output logic                             overflow,
    output logic                             underflow
);
    localparam int CW = cnt_width(DATA_DEPTH);
    localparam int PW = $clog2(DATA_DEPTH);
    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  overflow_q, overflow_d, underflow_q, underflow_d;
    logic                  wr_acc, rd_acc;
    assign empty        = count_q == '0;
    assign full         = count_q == CW'(DATA_DEPTH);
    assign almost_full  = count_q >= CW'(AFULL_THRESH);
    assign almost_empty = count_q <= CW'(AEMPTY_THRESH);
    // a write into a full FIFO is still accepted when a read frees the slot on the same edge
    always_comb begin
        rd_acc       = read_en && !empty;
        wr_acc       = write_en && (!full || rd_acc);
        count_d      = count_q + CW'(wr_acc) - CW'(rd_acc);
        dout_d       = (FWFT == FIFO_STD && rd_acc) ? mem_q[rd_ptr] : dout_q;
        dout_valid_d = FWFT == FIFO_STD && rd_acc;
        overflow_d   = write_en && !wr_acc;
        underflow_d  = read_en && !rd_acc;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr] <= din;
    end
    fifo_wrap_ctr #(.N(DATA_DEPTH)) u_wr_ctr (.clk(clk), .reset_n(reset_n), .inc(wr_acc), .value(wr_ptr));
    fifo_wrap_ctr #(.N(DATA_DEPTH)) u_rd_ctr (.clk(clk), .reset_n(reset_n), .inc(rd_acc), .value(rd_ptr));
    assign dout       = (FWFT == FIFO_FWFT) ? mem_q[rd_ptr] : dout_q;
    assign dout_valid = (FWFT == FIFO_FWFT) ? !empty : dout_valid_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: three FIFO configurations checked every cycle against a list-based occupancy model
module tb_sync_fifo_flags;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] din [3];
    logic       we [3], re [3];
    logic [7:0] dout [3];
    logic       dv [3], emp [3], ful [3], af [3], ae [3], ovf [3], unf [3];
    logic [3:0] cnt0, cnt2;
    logic [2:0] cnt1;
    logic [3:0] cnt [3];
    int         D [3]   = '{8, 6, 8};
    int         AFT [3] = '{7, 5, 7};
    int         AET [3] = '{1, 1, 1};
    bit         FW [3]  = '{1'b0, 1'b0, 1'b1};
    logic [7:0] mdat [3][16];
    int         mcnt [3] = '{0, 0, 0};
    logic [7:0] exp_dout [3];
    bit         exp_dv [3], exp_ovf [3], exp_unf [3];
    int         nchk = 0, nerr = 0;
    always #5 clk = ~clk;
    always_comb begin
        cnt[0] = cnt0;
        cnt[1] = {1'b0, cnt1};
        cnt[2] = cnt2;
    end
    sync_fifo_flags #(.DATA_WIDTH(8)) u_std8 (
        .clk(clk), .reset_n(reset_n), .din(din[0]), .write_en(we[0]), .read_en(re[0]),
        .dout(dout[0]), .dout_valid(dv[0]), .empty(emp[0]), .full(ful[0]), .almost_full(af[0]),
        .almost_empty(ae[0]), .count(cnt0), .overflow(ovf[0]), .underflow(unf[0]));
    sync_fifo_flags #(.DATA_WIDTH(8), .DATA_DEPTH(6), .AFULL_THRESH(5), .AEMPTY_THRESH(1)) u_std6 (
        .clk(clk), .reset_n(reset_n), .din(din[1]), .write_en(we[1]), .read_en(re[1]),
        .dout(dout[1]), .dout_valid(dv[1]), .empty(emp[1]), .full(ful[1]), .almost_full(af[1]),
        .almost_empty(ae[1]), .count(cnt1), .overflow(ovf[1]), .underflow(unf[1]));
    sync_fifo_flags #(.DATA_WIDTH(8), .FWFT(1)) u_fwft8 (
        .clk(clk), .reset_n(reset_n), .din(din[2]), .write_en(we[2]), .read_en(re[2]),
        .dout(dout[2]), .dout_valid(dv[2]), .empty(emp[2]), .full(ful[2]), .almost_full(af[2]),
        .almost_empty(ae[2]), .count(cnt2), .overflow(ovf[2]), .underflow(unf[2]));
    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, idx, act, exp, $time);
        end
    endtask
    task automatic mreset(input int i);
        mcnt[i] = 0;
        exp_dout[i] = 8'h00;
        exp_dv[i] = 1'b0;
        exp_ovf[i] = 1'b0;
        exp_unf[i] = 1'b0;
    endtask
    // the model is an ordered list: pop shifts everything down, push appends at the tail
    task automatic mstep(input int i);
        bit rd, wr;
        rd = re[i] && mcnt[i] > 0;
        wr = we[i] && (mcnt[i] < D[i] || rd);
        exp_ovf[i] = we[i] && !wr;
        exp_unf[i] = re[i] && !rd;
        if (!FW[i]) begin
            exp_dv[i] = rd;
            if (rd) exp_dout[i] = mdat[i][0];
        end
        if (rd) begin
            for (int j = 0; j < 15; j++) mdat[i][j] = mdat[i][j + 1];
            mcnt[i]--;
        end
        if (wr) begin
            mdat[i][mcnt[i]] = din[i];
            mcnt[i]++;
        end
    endtask
    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset_n) mreset(i);
            else mstep(i);
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            check("count", i, cnt[i], mcnt[i]);
            check("empty", i, emp[i], mcnt[i] == 0);
            check("full", i, ful[i], mcnt[i] == D[i]);
            check("almost_full", i, af[i], mcnt[i] >= AFT[i]);
            check("almost_empty", i, ae[i], mcnt[i] <= AET[i]);
            check("overflow", i, ovf[i], exp_ovf[i]);
            check("underflow", i, unf[i], exp_unf[i]);
            check("dout_valid", i, dv[i], FW[i] ? mcnt[i] > 0 : exp_dv[i]);
            if (!FW[i]) check("dout", i, dout[i], exp_dout[i]);
            else if (mcnt[i] > 0) check("dout_fwft", i, dout[i], mdat[i][0]);
        end
    end
    initial begin
        for (int i = 0; i < 3; i++) begin
            we[i] = 1'b0;
            re[i] = 1'b0;
            din[i] = 8'h00;
        end
        repeat (2) @(negedge clk);
        check("rst_empty", 0, emp[0], 1);
        check("rst_almost_empty", 0, ae[0], 1);
        check("rst_full", 0, ful[0], 0);
        check("rst_count", 0, cnt[0], 0);
        check("rst_dout", 0, dout[0], 0);
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            we[0] = 1'b1;
            din[0] = 8'(k);
            @(negedge clk);
        end
        check("fill_full", 0, ful[0], 1);
        check("fill_count", 0, cnt[0], 8);
        din[0] = 8'h08;
        @(negedge clk);
        we[0] = 1'b0;
        check("fill_overflow", 0, ovf[0], 1);
        check("fill_count_hold", 0, cnt[0], 8);
        for (int k = 0; k < 8; k++) begin
            re[0] = 1'b1;
            @(negedge clk);
            check("readback", k, dout[0], k);
        end
        re[0] = 1'b0;
        check("drained_empty", 0, emp[0], 1);
        re[0] = 1'b1;
        @(negedge clk);
        check("uf_pulse", 0, unf[0], 1);
        check("uf_valid", 0, dv[0], 0);
        check("uf_count", 0, cnt[0], 0);
        we[0] = 1'b1;
        din[0] = 8'hA5;
        @(negedge clk);
        we[0] = 1'b0;
        check("uf_rw_pulse", 0, unf[0], 1);
        check("uf_rw_count", 0, cnt[0], 1);
        @(negedge clk);
        re[0] = 1'b0;
        check("uf_rw_data", 0, dout[0], 8'hA5);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            we[0] = 1'b1;
            din[0] = 8'h10 + 8'(k);
            @(negedge clk);
        end
        re[0] = 1'b1;
        din[0] = 8'h55;
        @(negedge clk);
        we[0] = 1'b0;
        check("full_rw_overflow", 0, ovf[0], 0);
        check("full_rw_count", 0, cnt[0], 8);
        check("full_rw_data", 0, dout[0], 8'h10);
        repeat (8) @(negedge clk);
        re[0] = 1'b0;
        check("full_rw_last", 0, dout[0], 8'h55);
        check("full_rw_empty", 0, emp[0], 1);
        we[2] = 1'b1;
        din[2] = 8'h11;
        @(negedge clk);
        check("fwft_first", 2, dout[2], 8'h11);
        check("fwft_valid", 2, dv[2], 1);
        din[2] = 8'h22;
        @(negedge clk);
        we[2] = 1'b0;
        re[2] = 1'b1;
        @(negedge clk);
        check("fwft_second", 2, dout[2], 8'h22);
        @(negedge clk);
        re[2] = 1'b0;
        check("fwft_empty", 2, emp[2], 1);
        check("fwft_invalid", 2, dv[2], 0);
        for (int k = 0; k < 20; k++) begin
            we[1] = 1'b1;
            din[1] = 8'h30 + 8'(k);
            re[1] = k % 2 == 1;
            @(negedge clk);
        end
        we[1] = 1'b0;
        re[1] = 1'b1;
        repeat (8) @(negedge clk);
        re[1] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            we[0] = 1'b1;
            din[0] = 8'h40 + 8'(k);
            @(negedge clk);
        end
        we[0] = 1'b0;
        re[0] = 1'b1;
        @(negedge clk);
        re[0] = 1'b0;
        check("pre_rst_valid", 0, dv[0], 1);
        check("pre_rst_count", 0, cnt[0], 5);
        #2 reset_n = 1'b0;
        #1;
        check("async_count", 0, cnt[0], 0);
        check("async_empty", 0, emp[0], 1);
        check("async_full", 0, ful[0], 0);
        check("async_valid", 0, dv[0], 0);
        @(negedge clk);
        reset_n = 1'b1;
        we[0] = 1'b1;
        din[0] = 8'h77;
        @(negedge clk);
        we[0] = 1'b0;
        re[0] = 1'b1;
        @(negedge clk);
        re[0] = 1'b0;
        check("post_rst_data", 0, dout[0], 8'h77);
        check("post_rst_count", 0, cnt[0], 0);
        for (int c = 0; c < 450; c++) begin
            for (int i = 0; i < 3; i++) begin
                int wp;
                wp = c < 150 ? 75 : c < 300 ? 25 : 50;
                we[i] = $urandom_range(0, 99) < wp;
                re[i] = $urandom_range(0, 99) < 100 - wp;
                din[i] = 8'($urandom);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            we[i] = 1'b0;
            re[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
